instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Supplies `instruction_code` to the single-cycle RISC-V `processor` core: the producer side of that core's instruction input.
- Holds a loadable word-addressed program memory, a fetch PC, and a 2-entry prefetch buffer with a valid/ready handshake toward the core.
- Redirects on a taken branch, using the core's `zero` flag gated by a branch strobe.
- Stops on ECALL (`0x00000073`).

Parameters:
- ADDR_WIDTH, 8, word-address bits of program memory (depth 2^ADDR_WIDTH words).
- RESET_PC, 32'h0000_0000, byte address fetched first after reset or restart (bits [1:0] must be 0).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load_en  input  1  program-memory write strobe; honoured only in IDLE or HALT
- load_addr  input  ADDR_WIDTH  word address for load
- load_data  input  32  instruction word to store
- run  input  1  level: high = fetch, low = stop/return to IDLE
- instr_ready  input  1  core accepts the presented instruction this cycle
- branch_en  input  1  core is executing a branch this cycle
- zero  input  1  core ALU zero flag; taken = branch_en & zero
- redirect_pc  input  32  branch target byte address
- instruction_code  output  32  instruction presented to core
- instr_valid  output  1  instruction_code/pc are valid
- pc  output  32  byte address of presented instruction
- halted  output  1  high while in HALT

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; fetch_pc = RESET_PC; buffer empty; in-flight cleared.
  - instruction_code = 0, instr_valid = 0, pc = RESET_PC, halted = 0.
  - Memory contents are not reset.
- Memory:
  - Synchronous write: `load_en` in IDLE/HALT writes `mem[load_addr]` at the edge.
  - Synchronous read with 1-cycle latency.
  - Loads in FETCH are ignored.
- States:
  - IDLE:
    - run=1 → FETCH, fetch_pc = RESET_PC.
    - Otherwise stay.
  - FETCH:
    - Issue a read of `mem[fetch_pc[ADDR_WIDTH+1:2]]` when (buffer occupancy + in-flight) < 2 and run=1; fetch_pc += 4 on issue.
    - Read data plus its PC enter the buffer next cycle.
    - run=0: no new issues; buffer and in-flight read are discarded; → IDLE next edge; instr_valid drops the same edge.
  - HALT:
    - Entered at the edge where the buffer head equals 32'h00000073 with instr_valid & instr_ready.
    - Buffer and in-flight read are discarded; halted=1, instr_valid=0.
    - run=0 → IDLE, halted=0.
- Output and handshake:
  - instruction_code, pc, and instr_valid reflect the buffer head, registered.
  - A head is popped only when instr_valid & instr_ready.
  - instruction_code/pc must hold stable while instr_valid=1 and instr_ready=0.
  - When empty: instr_valid=0 and instruction_code holds its last value.
- Latency:
  - run sampled high at edge N (IDLE→FETCH); read issued edge N+1; instr_valid=1 after edge N+2.
  - With instr_ready held high, one instruction per cycle is delivered with no bubbles.
- Redirect (taken = branch_en & zero, FETCH only):
  - The head, if valid and ready, is accepted.
  - All remaining buffered entries are flushed, and the in-flight read is tagged stale and dropped.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; a read of the target is issued the next edge.
  - instr_valid=0 for exactly 2 cycles after the taken edge before the target appears.
  - A taken branch in the same cycle as an ECALL accept: HALT wins.
  - branch_en & !zero: no effect.
- Wrap: the word index wraps modulo 2^ADDR_WIDTH; the pc output carries fetch_pc with bits above ADDR_WIDTH+1 cleared.
- Reset mid-operation: immediate return to the reset values above; in-flight data is discarded.

Test Plan:
- Reset/idle:
  - Stimulus: reset=0 for 2 cycles, run=0.
  - Response: instr_valid=0, pc=0, halted=0, instruction_code=0; load_en writes accepted.
- Straight-line fetch:
  - Stimulus: load mem[0]=32'h015A04B3 (add x9,x20,x21), mem[1]=32'h00000013, mem[2]=32'h00000073; run=1, instr_ready=1.
  - Response: first valid 2 cycles after run; pc 0,4,8 on consecutive cycles with matching words; halted=1 after ECALL accepted; no further valid.
- Backpressure:
  - Stimulus: same program, instr_ready=0 for 5 cycles after first valid.
  - Response: instruction_code stays 32'h015A04B3, pc=0; no read issued beyond occupancy 2; resumes 4,8 in order without loss or duplication.
- Taken branch:
  - Stimulus: branch_en=1, zero=1, redirect_pc=32'h20 while the head is at pc=4.
  - Response: pc=4 accepted; pc=8 never presented; instr_valid low 2 cycles; next valid pc=0x20 with mem[8].
  - Repeat with zero=0: no redirect.
- Wrap and misalignment:
  - Stimulus: ADDR_WIDTH=8, redirect_pc=32'h3FE.
  - Response: fetch at 0x3FC then 0x000.
- Abort:
  - Stimulus: reset asserted mid-FETCH with 2 buffered entries, then run toggled 0→1.
  - Response: immediate instr_valid=0, pc=RESET_PC; restart delivers pc=0 first.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end for the single-cycle RISC-V core: loadable program memory,
// fetch PC, two-entry prefetch buffer and a valid/ready instruction port with branch redirect.
module instruction_fetch_unit #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic                  run,
    input  logic                  instr_ready,
    input  logic                  branch_en,
    input  logic                  zero,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           instruction_code,
    output logic                  instr_valid,
    output logic [31:0]           pc,
    output logic                  halted,
    output logic [1:0]            state_dbg
);

    localparam int          PW    = ADDR_WIDTH + 2;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

    // Handshake: the head (instruction_code/pc) transfers on a cycle where
    // instr_valid & instr_ready; while valid and not ready the head holds stable.

    state_t          state, state_next;
    logic [PW-1:0]   fetch_pc;
    logic            infl_valid;
    logic [PW-1:0]   infl_pc;
    logic [31:0]     rd_data;
    logic            sk_valid;
    logic [31:0]     sk_code;
    logic [PW-1:0]   sk_pc;
    logic [31:0]     mem [0:(1<<ADDR_WIDTH)-1];

    logic            pop, flush, taken, issue, start;
    logic [1:0]      used;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^{redirect_pc[31:PW], redirect_pc[1:0]};

    // Slots committed after this cycle's pop; counting the pop keeps full throughput.
    assign used = 2'(instr_valid) + 2'(sk_valid) + 2'(infl_valid) - 2'(pop);

    always_comb begin
        state_next = state;
        pop        = instr_valid & instr_ready;
        flush      = 1'b0;
        taken      = 1'b0;
        issue      = 1'b0;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                    start      = 1'b1;
                end
            end
            FETCH: begin
                if (!run) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else if (pop && instruction_code == ECALL) begin
                    state_next = HALT;
                    flush      = 1'b1;
                end else if (branch_en && zero) begin
                    taken = 1'b1;
                    flush = 1'b1;
                end else begin
                    issue = (used < 2'd2);
                end
            end
            HALT: begin
                if (!run) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (load_en && state != FETCH) mem[load_addr] <= load_data;
        if (issue) rd_data <= mem[fetch_pc[PW-1:2]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            fetch_pc         <= RESET_PC[PW-1:0];
            infl_valid       <= 1'b0;
            infl_pc          <= '0;
            sk_valid         <= 1'b0;
            sk_code          <= '0;
            sk_pc            <= '0;
            instr_valid      <= 1'b0;
            instruction_code <= '0;
            pc               <= RESET_PC;
        end else begin
            state <= state_next;

            if (start)      fetch_pc <= RESET_PC[PW-1:0];
            else if (taken) fetch_pc <= {redirect_pc[PW-1:2], 2'b00};
            else if (issue) fetch_pc <= fetch_pc + PW'(4);

            infl_valid <= issue;
            if (issue) infl_pc <= fetch_pc;

            // A flush also drops the read landing this edge; nothing is issued on a flush edge.
            if (flush) begin
                instr_valid <= 1'b0;
                sk_valid    <= 1'b0;
            end else if (pop) begin
                if (sk_valid) begin
                    instruction_code <= sk_code;
                    pc               <= 32'(sk_pc);
                    instr_valid      <= 1'b1;
                    sk_valid         <= infl_valid;
                    sk_code          <= rd_data;
                    sk_pc            <= infl_pc;
                end else if (infl_valid) begin
                    instruction_code <= rd_data;
                    pc               <= 32'(infl_pc);
                    instr_valid      <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end else if (infl_valid) begin
                if (!instr_valid) begin
                    instruction_code <= rd_data;
                    pc               <= 32'(infl_pc);
                    instr_valid      <= 1'b1;
                end else begin
                    sk_code  <= rd_data;
                    sk_pc    <= infl_pc;
                    sk_valid <= 1'b1;
                end
            end
        end
    end

    assign halted    = (state == HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table plus hand-written
// reset and abort sequences.
module tb_instruction_fetch_unit;

    localparam logic [31:0] W_ADD  = 32'h015A04B3;
    localparam logic [31:0] W_NOP  = 32'h00000013;
    localparam logic [31:0] W_EC   = 32'h00000073;
    localparam logic [31:0] W_TGT  = 32'h00200113;
    localparam logic [31:0] W_TOP  = 32'hAAAA0001;
    localparam logic [31:0] W_BAD  = 32'hDEADBEEF;

    logic        clock, reset, load_en, run, instr_ready, branch_en, zero;
    logic [7:0]  load_addr;
    logic [31:0] load_data, redirect_pc, instruction_code, pc;
    logic        instr_valid, halted;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    instruction_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .run(run), .instr_ready(instr_ready),
        .branch_en(branch_en), .zero(zero), .redirect_pc(redirect_pc),
        .instruction_code(instruction_code), .instr_valid(instr_valid), .pc(pc),
        .halted(halted), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        run, rdy, br, zero;
        logic [31:0] redir;
        logic        ld;
        logic [7:0]  ld_addr;
        logic [31:0] ld_data;
        logic        ev, eh;
        logic [31:0] epc, ecode;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rd, input logic b, input logic z,
                       input logic [31:0] rp, input logic ev, input logic eh,
                       input logic [31:0] epc, input logic [31:0] ecode);
        vec_t v;
        v.run = r; v.rdy = rd; v.br = b; v.zero = z; v.redir = rp;
        v.ld = 1'b0; v.ld_addr = '0; v.ld_data = '0;
        v.ev = ev; v.eh = eh; v.epc = epc; v.ecode = ecode;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; zero = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; redirect_pc = '0;

        // reset / idle
        repeat (2) step();
        check("rst_valid", -1, 32'(instr_valid), 32'd0);
        check("rst_pc", -1, pc, 32'h0);
        check("rst_halted", -1, 32'(halted), 32'd0);
        check("rst_code", -1, instruction_code, 32'h0);
        check("rst_state", -1, 32'(state_dbg), 32'd0);
        reset = 1'b1;
        step();
        load_word(8'd0, W_ADD);
        load_word(8'd1, W_NOP);
        load_word(8'd2, W_EC);
        load_word(8'd3, W_NOP);
        load_word(8'd8, W_TGT);
        load_word(8'd9, W_EC);
        load_word(8'd255, W_TOP);

        // straight-line fetch to ECALL
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,0,0,0, 1,0, 32'h4, W_NOP);
        add(1,1,0,0,0, 1,0, 32'h8, W_EC);
        add(1,1,0,0,0, 0,1, 0,0);
        add(1,1,0,0,0, 0,1, 0,0);
        add(0,1,0,0,0, 0,0, 0,0);
        // backpressure: ready low for 5 cycles after first valid
        add(1,0,0,0,0, 0,0, 0,0);
        add(1,0,0,0,0, 0,0, 0,0);
        add(1,0,0,0,0, 1,0, 32'h0, W_ADD);
        for (int i = 0; i < 5; i++) add(1,0,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,0,0,0, 1,0, 32'h4, W_NOP);
        add(1,1,0,0,0, 1,0, 32'h8, W_EC);
        add(1,1,0,0,0, 0,1, 0,0);
        add(0,1,0,0,0, 0,0, 0,0);
        // taken branch while head is pc=4
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,0,0,0, 1,0, 32'h4, W_NOP);
        add(1,1,1,1,32'h20, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 32'h20, W_TGT);
        add(1,1,0,0,0, 1,0, 32'h24, W_EC);
        add(1,1,0,0,0, 0,1, 0,0);
        add(0,1,0,0,0, 0,0, 0,0);
        // not taken: branch without zero, zero without branch
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,0,1,32'h20, 1,0, 32'h4, W_NOP);
        add(1,1,1,0,32'h20, 1,0, 32'h8, W_EC);
        add(1,1,0,0,0, 0,1, 0,0);
        add(0,1,0,0,0, 0,0, 0,0);
        // misaligned redirect near top of memory wraps to 0; load during fetch ignored
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,1,1,32'h3FE, 0,0, 0,0);
        add(1,1,0,0,0, 0,0, 0,0);
        vecs[vecs.size()-1].ld = 1'b1;
        vecs[vecs.size()-1].ld_addr = 8'd1;
        vecs[vecs.size()-1].ld_data = W_BAD;
        add(1,1,0,0,0, 1,0, 32'h3FC, W_TOP);
        add(1,1,0,0,0, 1,0, 32'h0, W_ADD);
        add(1,1,0,0,0, 1,0, 32'h4, W_NOP);
        add(0,1,0,0,0, 0,0, 0,0);
        add(0,0,0,0,0, 0,0, 0,0);

        foreach (vecs[i]) begin
            run = vecs[i].run; instr_ready = vecs[i].rdy;
            branch_en = vecs[i].br; zero = vecs[i].zero; redirect_pc = vecs[i].redir;
            load_en = vecs[i].ld; load_addr = vecs[i].ld_addr; load_data = vecs[i].ld_data;
            step();
            check("valid", i, 32'(instr_valid), 32'(vecs[i].ev));
            check("halted", i, 32'(halted), 32'(vecs[i].eh));
            if (vecs[i].ev) begin
                check("pc", i, pc, vecs[i].epc);
                check("code", i, instruction_code, vecs[i].ecode);
            end
        end
        load_en = 1'b0; branch_en = 1'b0; zero = 1'b0;

        // abort: async reset with two buffered entries, then restart
        run = 1'b1; instr_ready = 1'b0;
        repeat (3) step();
        check("abort_pre_valid", -2, 32'(instr_valid), 32'd1);
        check("abort_pre_pc", -2, pc, 32'h0);
        step();
        reset = 1'b0; run = 1'b0;
        #1;
        check("abort_valid", -2, 32'(instr_valid), 32'd0);
        check("abort_pc", -2, pc, 32'h0);
        check("abort_code", -2, instruction_code, 32'h0);
        check("abort_halted", -2, 32'(halted), 32'd0);
        step();
        reset = 1'b1;
        step();
        run = 1'b1; instr_ready = 1'b1;
        step();
        check("restart_v0", -3, 32'(instr_valid), 32'd0);
        step();
        check("restart_v1", -3, 32'(instr_valid), 32'd0);
        step();
        check("restart_valid", -3, 32'(instr_valid), 32'd1);
        check("restart_pc", -3, pc, 32'h0);
        check("restart_code", -3, instruction_code, W_ADD);
        step();
        check("restart_pc2", -3, pc, 32'h4);
        run = 1'b0;
        step();
        check("restart_stop", -3, 32'(instr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
